// File: rtl/mem_access_ctrl.sv
// Load/store initiator: turns CPU byte/half/word requests into word accesses on a
// combinational-read RAM, using read-modify-write for sub-word stores. Optional macro: MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
  parameter int                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h10010000,
  parameter int                  DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = 'hFF;
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = 'hFFFF;

  state_t                state_reg, state_next;
  logic                  we_reg, we_next;
  logic [1:0]            size_reg, size_next;
  logic                  uns_reg, uns_next;
  logic [1:0]            lane_reg, lane_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_err_reg, rsp_err_next;

  logic                  req_err;
  logic                  out_of_range;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] shifted_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_data;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] LIMIT_ADDR = BASE_ADDR + DATA_WIDTH'(4 * DEPTH);
  assign out_of_range = (req_addr < BASE_ADDR) || (req_addr >= LIMIT_ADDR);
`else
  // Out-of-range addresses go straight to the RAM and wrap there.
  assign out_of_range = 1'b0;
`endif

  assign req_err = (req_size == 2'b11)
                || ((req_size == SIZE_HALF) && req_addr[0])
                || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                || out_of_range;

  // Lane position in bits: byte k at 8k, half at 0 or 16.
  assign shamt     = (size_reg == SIZE_BYTE) ? {lane_reg, 3'b000} : {lane_reg[1], 4'b0000};
  assign lane_mask = (size_reg == SIZE_BYTE) ? (BYTE_MASK << shamt) : (HALF_MASK << shamt);
  assign shifted_q = mem_q >> shamt;

  always_comb begin
    load_data = mem_q;
    if (size_reg == SIZE_BYTE)
      load_data = {{(DATA_WIDTH-8){shifted_q[7] & ~uns_reg}}, shifted_q[7:0]};
    else if (size_reg == SIZE_HALF)
      load_data = {{(DATA_WIDTH-16){shifted_q[15] & ~uns_reg}}, shifted_q[15:0]};
  end

  assign merged_data = (mem_q & ~lane_mask) | ((wdata_reg << shamt) & lane_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      size_reg      <= SIZE_BYTE;
      uns_reg       <= 1'b0;
      lane_reg      <= 2'b00;
      wdata_reg     <= '0;
      mem_addr_reg  <= BASE_ADDR;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      we_reg        <= we_next;
      size_reg      <= size_next;
      uns_reg       <= uns_next;
      lane_reg      <= lane_next;
      wdata_reg     <= wdata_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    we_next        = we_reg;
    size_next      = size_reg;
    uns_next       = uns_reg;
    lane_next      = lane_reg;
    wdata_next     = wdata_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = '0;
    rsp_err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          we_next       = req_we;
          size_next     = req_size;
          uns_next      = req_unsigned;
          lane_next     = req_addr[1:0];
          wdata_next    = req_wdata;
          mem_addr_next = {req_addr[DATA_WIDTH-1:2], 2'b00};
          if (req_err) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            state_next     = RESP;
          end else if (req_we && (req_size == SIZE_WORD)) begin
            mem_wdata_next = req_wdata;
            state_next     = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        if (we_reg) begin
          mem_wdata_next = merged_data;
          state_next     = WR;
        end else begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = load_data;
          state_next     = RESP;
        end
      end
      WR: begin
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        mem_addr_next = BASE_ADDR;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and write strobe are gated so reset takes effect within the cycle.
  assign req_ready = rst_n && (state_reg == IDLE);
  assign mem_we    = rst_n && (state_reg == WR);
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 64-word combinational-read RAM.
module tb_mem_access_ctrl;

  localparam logic [31:0] BASE = 32'h10010000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_q;
  logic [31:0] ram [0:63];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_q(mem_q)
  );

  assign mem_q = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: latency counted in cycles from the accepting edge to rsp_valid.
  task automatic xact(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
    int lat;
    int wes;
    @(negedge clk);
    chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; wes = 0;
    while (!rsp_valid && lat < 8) begin
      if (mem_we) wes++;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
    chk({tag, ".we_pulses"}, wes, (we && !exp_err) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk({tag, ".rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, ".idle_addr"}, mem_addr, BASE);
    $display("xact %s lat=%0d err=%0b rdata=%h", tag, lat, rsp_err, rsp_rdata);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = BASE; req_wdata = 32'h0;

    // Reset held with a request pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.ready", {31'b0, req_ready}, 32'd0);
      chk("rst.we", {31'b0, mem_we}, 32'd0);
      chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst.mem_addr", mem_addr, BASE);
    end
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.err", {31'b0, rsp_err}, 32'd0);
    $display("reset held 3 cycles");
    req_valid = 1'b0;
    rst_n = 1'b1;

    // Word store then load
    xact("sw1", 1, 2'b10, 0, 32'h10010004, 32'hDEADBEEF, 2, 0, 32'h0);
    chk("sw1.ram", ram[1], 32'hDEADBEEF);
    xact("lw1", 0, 2'b10, 0, 32'h10010004, 32'h0, 2, 0, 32'hDEADBEEF);

    // Byte read-modify-write and byte loads
    xact("sw0", 1, 2'b10, 0, 32'h10010000, 32'h11223344, 2, 0, 32'h0);
    xact("sb0", 1, 2'b00, 0, 32'h10010002, 32'h123456AA, 3, 0, 32'h0);
    chk("sb0.ram", ram[0], 32'h11AA3344);
    xact("lb0", 0, 2'b00, 0, 32'h10010002, 32'h0, 2, 0, 32'hFFFFFFAA);
    xact("lbu0", 0, 2'b00, 1, 32'h10010002, 32'h0, 2, 0, 32'h000000AA);
    xact("lbu3", 0, 2'b00, 1, 32'h10010003, 32'h0, 2, 0, 32'h00000011);

    // Half-word store into upper lane and half loads
    xact("sw1z", 1, 2'b10, 0, 32'h10010004, 32'h0, 2, 0, 32'h0);
    xact("sh1", 1, 2'b01, 0, 32'h10010006, 32'hFFFF8001, 3, 0, 32'h0);
    chk("sh1.ram", ram[1], 32'h80010000);
    xact("lh1", 0, 2'b01, 0, 32'h10010006, 32'h0, 2, 0, 32'hFFFF8001);
    xact("lhu1", 0, 2'b01, 1, 32'h10010006, 32'h0, 2, 0, 32'h00008001);
    xact("lh0", 0, 2'b01, 0, 32'h10010000, 32'h0, 2, 0, 32'h00003344);

    // Misaligned and reserved-size errors
    xact("lw_mis", 0, 2'b10, 0, 32'h10010002, 32'h0, 1, 1, 32'h0);
    xact("sh_mis", 1, 2'b01, 0, 32'h10010001, 32'h0000BEEF, 1, 1, 32'h0);
    chk("sh_mis.ram", ram[0], 32'h11AA3344);
    xact("sz11", 1, 2'b11, 0, 32'h10010000, 32'h0, 1, 1, 32'h0);
    chk("sz11.ram", ram[0], 32'h11AA3344);

    // Address one past the RAM
`ifdef MEM_BOUNDS_CHECK_EN
    xact("bnd_sw", 1, 2'b10, 0, 32'h10010100, 32'hCAFEF00D, 1, 1, 32'h0);
    chk("bnd_sw.ram", ram[0], 32'h11AA3344);
`else
    xact("bnd_sw", 1, 2'b10, 0, 32'h10010100, 32'hCAFEF00D, 2, 0, 32'h0);
    chk("bnd_sw.ram_wrap", ram[0], 32'hCAFEF00D);
`endif

    // Reset asserted during the WR cycle of a byte store
    xact("sw2", 1, 2'b10, 0, 32'h10010008, 32'h55667788, 2, 0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10010009; req_wdata = 32'h00000099;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst.we_before", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.we_gated", {31'b0, mem_we}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    chk("midrst.ram", ram[2], 32'h55667788);
    $display("reset during WR dropped store ram[2]=%h", ram[2]);
    xact("lw2", 0, 2'b10, 0, 32'h10010008, 32'h0, 2, 0, 32'h55667788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
